// File: rtl/qarma64_pkg.sv
// ============================================================================
// Package   : qarma64_pkg
// Purpose   : Shared constants, state type and tweak-schedule helper functions
//             for the QARMA-64 iterative datapath.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package qarma64_pkg;

  localparam int QARMA64_ROUNDS  = 7;
  localparam int QARMA64_TWEAK_W = 64;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_FWD  = 2'd1,
    TS_BWD  = 2'd2
  } tweak_seq_state_t;

  // Tweak cell permutation h: cell i of the result is taken from cell
  // TWEAK_PERM[i] of the input. Cell 0 is the most significant nibble.
  localparam int TWEAK_PERM [16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};

  // Cells that receive the 4-bit LFSR after permutation (bit i = cell i):
  // cells 0, 1, 3, 4, 8, 11 and 13.
  localparam logic [15:0] TWEAK_LFSR_CELLS = 16'h291B;

  // omega: (b3,b2,b1,b0) -> (b0^b1, b3, b2, b1)
  function automatic logic [3:0] lfsr_fwd(input logic [3:0] c);
    return {c[0] ^ c[1], c[3], c[2], c[1]};
  endfunction

  // omega^-1: (c3,c2,c1,c0) -> (c2, c1, c0, c3^c0)
  function automatic logic [3:0] lfsr_inv(input logic [3:0] c);
    return {c[2], c[1], c[0], c[3] ^ c[0]};
  endfunction

  // UpdateTweak: permute cells with h, then clock the LFSR on the marked cells.
  function automatic logic [63:0] update_tweak(input logic [63:0] t);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      p[63-4*i -: 4] = t[63-4*TWEAK_PERM[i] -: 4];
    end
    for (int i = 0; i < 16; i++) begin
      if (TWEAK_LFSR_CELLS[i]) begin
        p[63-4*i -: 4] = lfsr_fwd(p[63-4*i -: 4]);
      end
    end
    return p;
  endfunction

  // InvUpdateTweak: undo the LFSR on the marked cells, then apply h^-1.
  function automatic logic [63:0] inv_update_tweak(input logic [63:0] t);
    logic [63:0] q;
    logic [63:0] r;
    q = t;
    for (int i = 0; i < 16; i++) begin
      if (TWEAK_LFSR_CELLS[i]) begin
        q[63-4*i -: 4] = lfsr_inv(q[63-4*i -: 4]);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[63-4*TWEAK_PERM[i] -: 4] = q[63-4*i -: 4];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qarma64_tweak_step.sv
// ============================================================================
// Module    : qarma64_tweak_step
// Purpose   : One combinational tweak-schedule step; forward (UpdateTweak)
//             or backward (InvUpdateTweak) selected by dir.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module qarma64_tweak_step
  import qarma64_pkg::*;
(
  input  logic [QARMA64_TWEAK_W-1:0] tk,
  input  logic                       dir,
  output logic [QARMA64_TWEAK_W-1:0] newtk
);

  logic [QARMA64_TWEAK_W-1:0] fwd_tk;
  logic [QARMA64_TWEAK_W-1:0] bwd_tk;

  // Both directions are always evaluated; dir only steers the mux.
  assign fwd_tk = update_tweak(tk);
  assign bwd_tk = inv_update_tweak(tk);
  assign newtk  = dir ? bwd_tk : fwd_tk;

endmodule

`default_nettype wire

// File: rtl/qarma64_tweak_sequencer.sv
// ============================================================================
// Module    : qarma64_tweak_sequencer
// Purpose   : Streams the 2*ROUNDS round tweaks for one input tweak: forward
//             t0..t(R-1), then backward t(R-1)..t0 regenerated with the
//             inverse update, so no per-round tweak storage is needed.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module qarma64_tweak_sequencer
  import qarma64_pkg::*;
#(
  parameter int ROUNDS = QARMA64_ROUNDS,
  parameter int IDX_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [QARMA64_TWEAK_W-1:0] in_tweak,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [QARMA64_TWEAK_W-1:0] out_tk,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_dir,
  output logic                       out_last,
  output logic                       busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  tweak_seq_state_t           state;
  logic [QARMA64_TWEAK_W-1:0] tk_reg;
  logic [IDX_W-1:0]           idx;
  logic [QARMA64_TWEAK_W-1:0] step_tk;
  logic                       step_dir;

  // In BWD the step runs the inverse schedule, walking back toward t0.
  assign step_dir = (state == TS_BWD);

  qarma64_tweak_step u_step (
    .tk    (tk_reg),
    .dir   (step_dir),
    .newtk (step_tk)
  );

  // Sequencing state: the turnaround beat at R-1 keeps tk_reg/idx so that
  // t(R-1) appears once in each half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= TS_IDLE;
      tk_reg <= '0;
      idx    <= '0;
    end else begin
      case (state)
        TS_IDLE: begin
          if (in_valid) begin
            tk_reg <= in_tweak;
            idx    <= '0;
            state  <= TS_FWD;
          end
        end
        TS_FWD: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state <= TS_BWD;
            end else begin
              tk_reg <= step_tk;
              idx    <= idx + IDX_W'(1);
            end
          end
        end
        TS_BWD: begin
          if (out_ready) begin
            if (idx == '0) begin
              state <= TS_IDLE;
            end else begin
              tk_reg <= step_tk;
              idx    <= idx - IDX_W'(1);
            end
          end
        end
        default: state <= TS_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registers so they hold steady under stall.
  assign in_ready  = (state == TS_IDLE) & ~rst;
  assign out_valid = (state != TS_IDLE);
  assign busy      = (state != TS_IDLE);
  assign out_tk    = tk_reg;
  assign out_idx   = idx;
  assign out_dir   = (state == TS_BWD);
  assign out_last  = (state == TS_BWD) & (idx == '0);

endmodule

`default_nettype wire

// File: tb/tb_qarma64_tweak_sequencer.sv
// ============================================================================
// Module    : tb_qarma64_tweak_sequencer
// Purpose   : Scoreboard bench for the tweak sequencer (ROUNDS=7 and ROUNDS=1).
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qarma64_tweak_sequencer;

  typedef struct packed {
    logic [63:0] tk;
    logic [2:0]  idx;
    logic        dir;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_v  [2];
  logic        in_ready_v  [2];
  logic [63:0] in_tweak_v  [2];
  logic        out_valid_v [2];
  logic        out_ready_v [2];
  logic [63:0] out_tk_v    [2];
  logic [2:0]  out_idx_v   [2];
  logic        out_dir_v   [2];
  logic        out_last_v  [2];
  logic        busy_v      [2];

  bit bp_en     [2];
  bit hold_test [2];
  int qlen      [2];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Tweak schedule reference: result cell i comes from input cell H[i];
  // the cells listed in LC then get one LFSR clock.
  int H  [16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
  int LC [7]  = '{0, 1, 3, 4, 8, 11, 13};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model_update(input logic [63:0] t);
    logic [3:0]  n [16];
    logic [3:0]  m [16];
    logic [3:0]  c;
    logic [63:0] r;
    for (int i = 0; i < 16; i++) n[i] = t[63-4*i -: 4];
    for (int i = 0; i < 16; i++) m[i] = n[H[i]];
    for (int j = 0; j < 7; j++) begin
      c = m[LC[j]];
      m[LC[j]] = {c[0] ^ c[1], c[3], c[2], c[1]};
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[63-4*i -: 4] = m[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int R = (g == 0) ? 7 : 1;

    qarma64_tweak_sequencer #(.ROUNDS(R), .IDX_W(3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_tweak  (in_tweak_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_tk    (out_tk_v[g]),
      .out_idx   (out_idx_v[g]),
      .out_dir   (out_dir_v[g]),
      .out_last  (out_last_v[g]),
      .busy      (busy_v[g])
    );

    beat_t       exp_q [$];
    logic [63:0] ts    [$];
    beat_t       cur_b, prev_b, e;
    logic [63:0] t;
    bit          prev_stall = 1'b0;
    bit          prev_valid = 1'b0;
    bit          have_last  = 1'b0;
    int          acc_cyc    = 0;
    int          last_cyc   = 0;

    // Monitor/scoreboard: push expected beats on accept, pop on handshake.
    always @(negedge clk) begin
      cur_b = '{out_tk_v[g], out_idx_v[g], out_dir_v[g], out_last_v[g]};
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (out_valid_v[g]) chk("in_ready_while_busy", 64'(in_ready_v[g]), 64'd0);
        if (prev_stall) begin
          chk("stall_valid_hold", 64'(out_valid_v[g]), 64'd1);
          chk("stall_tk_hold", cur_b.tk, prev_b.tk);
          chk("stall_ctrl_hold", 64'({cur_b.idx, cur_b.dir, cur_b.last}),
              64'({prev_b.idx, prev_b.dir, prev_b.last}));
        end
        if (in_valid_v[g] && in_ready_v[g]) begin
          if (hold_test[g] && have_last) chk("accept_after_last_gap", 64'(cyc - last_cyc), 64'd1);
          ts.delete();
          t = in_tweak_v[g];
          for (int k = 0; k < R; k++) begin
            ts.push_back(t);
            t = model_update(t);
          end
          for (int k = 0; k < R; k++) exp_q.push_back('{ts[k], 3'(k), 1'b0, 1'b0});
          for (int k = R - 1; k >= 0; k--) exp_q.push_back('{ts[k], 3'(k), 1'b1, k == 0});
          acc_cyc = cyc;
        end
        if (out_valid_v[g] && !prev_valid) chk("first_beat_latency", 64'(cyc - acc_cyc), 64'd1);
        if (out_valid_v[g] && out_ready_v[g]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: actual tk=%h idx=%0d required no beat", cur_b.tk, cur_b.idx);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tk", cur_b.tk, e.tk);
            chk("beat_idx_dir_last", 64'({cur_b.idx, cur_b.dir, cur_b.last}),
                64'({e.idx, e.dir, e.last}));
          end
          if (out_last_v[g]) begin
            last_cyc  = cyc;
            have_last = 1'b1;
          end
        end
        prev_stall = out_valid_v[g] && !out_ready_v[g];
        prev_b     = cur_b;
        prev_valid = out_valid_v[g];
      end
      qlen[g] = exp_q.size();
    end
  end

  // Consumer: always ready, or ~50% random backpressure when enabled.
  initial begin
    out_ready_v[0] = 1'b1;
    out_ready_v[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++)
        out_ready_v[g] = bp_en[g] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input int g, input logic [63:0] tw);
    int n = 0;
    while (!in_ready_v[g] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready_v[g]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual in_ready=0 required 1 (dut %0d)", g);
    end
    in_valid_v[g] = 1'b1;
    in_tweak_v[g] = tw;
    @(posedge clk);
    #1;
    in_valid_v[g] = 1'b0;
    in_tweak_v[g] = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((qlen[g] != 0 || busy_v[g]) && n < 2000);
    checks++;
    if (qlen[g] != 0 || busy_v[g]) begin
      errors++;
      $display("FAIL seq_complete_timeout: actual pending=%0d busy=%0b required 0 0 (dut %0d)",
               qlen[g], busy_v[g], g);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int g = 0; g < 2; g++) begin
      in_valid_v[g] = 1'b0;
      in_tweak_v[g] = '0;
      bp_en[g]      = 1'b0;
      hold_test[g]  = 1'b0;
    end

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("in_ready_during_rst", 64'(in_ready_v[0]), 64'd0);
    chk("out_valid_during_rst", 64'(out_valid_v[0]), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_out_tk", out_tk_v[0], 64'd0);
    chk("rst_out_idx_dir_last", 64'({out_idx_v[0], out_dir_v[0], out_last_v[0]}), 64'd0);
    chk("rst_in_ready_r1", 64'(in_ready_v[1]), 64'd1);

    // Nominal vector
    send(0, 64'h477d469dec0b8762);
    wait_idle(0);

    // Random tweaks, full throughput (forward/backward symmetry)
    repeat (4) begin
      send(0, {$urandom, $urandom});
      wait_idle(0);
    end

    // Backpressure
    bp_en[0] = 1'b1;
    send(0, 64'h477d469dec0b8762);
    wait_idle(0);
    repeat (3) begin
      send(0, {$urandom, $urandom});
      wait_idle(0);
    end
    bp_en[0] = 1'b0;

    // in_valid held high while busy
    send(0, {$urandom, $urandom});
    hold_test[0]  = 1'b1;
    in_valid_v[0] = 1'b1;
    in_tweak_v[0] = 64'hffffffffffffffff;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_v[0] && n < 200);
    chk("hold_accept_seen", 64'(in_ready_v[0]), 64'd1);
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    hold_test[0]  = 1'b0;
    wait_idle(0);

    // ROUNDS = 1 instance
    send(1, 64'h0123456789abcdef);
    wait_idle(1);
    bp_en[1] = 1'b1;
    repeat (3) begin
      send(1, {$urandom, $urandom});
      wait_idle(1);
    end
    bp_en[1] = 1'b0;

    // Reset in the middle of a sequence
    send(0, {$urandom, $urandom});
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("midrst_in_ready", 64'(in_ready_v[0]), 64'd0);
    chk("midrst_busy", 64'(busy_v[0]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("postrst_out_tk", out_tk_v[0], 64'd0);
    chk("postrst_out_idx", 64'(out_idx_v[0]), 64'd0);
    @(posedge clk);
    #1;
    send(0, 64'h477d469dec0b8762);
    wait_idle(0);

    chk("pending_beats_dut0", 64'(qlen[0]), 64'd0);
    chk("pending_beats_dut1", 64'(qlen[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
